phased_way_ctrl: RTL and testbench
==================================

# phased_way_ctrl

Sequencing controller for one phased 4-way cache set access: tag arrays are read first, then only the single hitting or refilled way's data array is enabled. It sits between the request port and the four tag/data way arrays. It drives the one-hot data-way enable by decoding a 2-bit way number. On a miss it runs a refill handshake and chooses victims round-robin.

## Interface
- TAG_W, 8, tag width in bits
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept; high only in IDLE
- req_tag  input  TAG_W  lookup tag, sampled on accept (req_valid & req_ready)
- tag_en  output  1  read enable to all four tag arrays
- tag_rd  input  4*TAG_W  way tags; way w at bits [w*TAG_W +: TAG_W]; valid the cycle after tag_en
- way_valid  input  4  per-way valid bits, same timing as tag_rd
- data_en  output  4  one-hot data array enable; 4'b0000 when idle
- data_we  output  1  write strobe to the enabled data way (refill only)
- refill_req  output  1  miss fill request, held until refill_done
- refill_tag  output  TAG_W  latched tag for the refill
- refill_done  input  1  fill data ready; sampled only in REFILL
- resp_valid  output  1  one-cycle completion pulse
- resp_hit  output  1  1 = hit, 0 = serviced by refill
- resp_way  output  2  way that was accessed

## Operation
- States: IDLE, TAG, CMP, REFILL, DATA, RESP. All outputs are Moore-decoded from the state and internal registers.
- IDLE: req_ready=1. On accept, latch req_tag into tag_q and go to TAG.
- TAG: tag_en=1 for exactly one cycle, then go to CMP.
- CMP: match[w] = way_valid[w] & (tag_rd[w] == tag_q).
  - Any match: way_q = lowest matching index, hit_q=1, go to DATA.
  - No match: way_q = victim counter, hit_q=0, go to REFILL.
- REFILL: refill_req=1 and refill_tag=tag_q. When refill_done=1, go to DATA and increment the victim counter (2-bit, wraps 3→0).
- DATA: data_en = one-hot decode of way_q (00→0001, 01→0010, 10→0100, 11→1000), asserted for exactly one cycle. data_we = ~hit_q. Then go to RESP.
- RESP: resp_valid=1, resp_hit=hit_q, resp_way=way_q. Return to IDLE.
- Outside their states, data_en=0, data_we=0, tag_en=0, refill_req=0, resp_valid=0. refill_tag and resp_way/resp_hit are don't-care when not qualified.
- Multiple matching ways: the lowest index wins; no error is flagged.
- The victim counter changes only on refill completion; hits never advance it.

## Timing
- Reset (rst_n low, immediately): state=IDLE, victim counter=0, tag_q=0, way_q=0, hit_q=0.
- Output values during reset: req_ready=1; every other output is 0. No accept occurs while rst_n is low.
- Hit latency: accept at edge 0; TAG in cycle 1; CMP in cycle 2; DATA in cycle 3; RESP in cycle 4. req_ready returns high in cycle 5. One request per 5 cycles.
- Miss latency: 5 + N cycles, where N is the number of REFILL cycles (N≥1). If refill_done is already high on the first REFILL cycle, N=1.
- refill_done outside REFILL is ignored.
- req_valid outside IDLE is ignored; the request is not captured, and the requester must hold it until accepted.
- Reset asserted mid-operation aborts the access, returns to IDLE with the values above, and never emits resp_valid for the aborted request.

## Test plan
- Reset release, then req_tag=0x5A with way 2 matching → tag_en in cycle 1; data_en=0100, data_we=0 in cycle 3; resp_valid/resp_hit=1/resp_way=2 in cycle 4.
- Ways 1 and 3 both match 0x11 → data_en=0010, resp_way=1.
- Four consecutive misses with refill_done after 3 cycles each → victims 0,1,2,3. A fifth miss → victim 0 (wrap). Each miss shows data_we=1 in DATA and resp_hit=0.
- Tag matches but way_valid[w]=0 → treated as a miss; refill_req held until refill_done; refill_tag equals the request tag.
- refill_done pulsed while in IDLE or TAG → no effect. req_valid held during TAG/CMP → accepted only once.
- rst_n dropped during REFILL → refill_req falls immediately; no resp_valid; victim counter=0; the next miss victimizes way 0.

Source files
------------

// File: rtl/phased_way_ctrl.sv
// Phased 4-way set access sequencer: tag lookup first, then a single data-way enable.
// Misses run a refill handshake and pick victims round-robin.
module phased_way_ctrl #(
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               tag_en,
    input  logic [4*TAG_W-1:0] tag_rd,
    input  logic [3:0]         way_valid,
    output logic [3:0]         data_en,
    output logic               data_we,
    output logic               refill_req,
    output logic [TAG_W-1:0]   refill_tag,
    input  logic               refill_done,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [1:0]         resp_way
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TAG    = 3'd1,
        CMP    = 3'd2,
        REFILL = 3'd3,
        DATA   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t             state_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [1:0]         way_reg;
    logic [1:0]         victim_reg;
    logic               hit_reg;
    logic [3:0]         match;
    logic               any_match;
    logic [1:0]         match_way;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_match
            assign match[gi] = way_valid[gi] & (tag_rd[gi*TAG_W +: TAG_W] == tag_reg);
        end
    endgenerate

    // Lowest matching way wins when several ways alias the same tag.
    always_comb begin
        any_match = |match;
        match_way = 2'd0;
        if (match[0])      match_way = 2'd0;
        else if (match[1]) match_way = 2'd1;
        else if (match[2]) match_way = 2'd2;
        else if (match[3]) match_way = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            tag_reg    <= '0;
            way_reg    <= 2'd0;
            victim_reg <= 2'd0;
            hit_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        tag_reg   <= req_tag;
                        state_reg <= TAG;
                    end
                end
                TAG: state_reg <= CMP;
                CMP: begin
                    if (any_match) begin
                        way_reg   <= match_way;
                        hit_reg   <= 1'b1;
                        state_reg <= DATA;
                    end else begin
                        way_reg   <= victim_reg;
                        hit_reg   <= 1'b0;
                        state_reg <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_done) begin
                        victim_reg <= victim_reg + 2'd1;
                        state_reg  <= DATA;
                    end
                end
                DATA:    state_reg <= RESP;
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Moore outputs; qualified-only fields are forced to zero outside their state.
    assign req_ready  = (state_reg == IDLE);
    assign tag_en     = (state_reg == TAG);
    assign data_en    = (state_reg == DATA) ? (4'b0001 << way_reg) : 4'b0000;
    assign data_we    = (state_reg == DATA) & ~hit_reg;
    assign refill_req = (state_reg == REFILL);
    assign refill_tag = (state_reg == REFILL) ? tag_reg : '0;
    assign resp_valid = (state_reg == RESP);
    assign resp_hit   = (state_reg == RESP) & hit_reg;
    assign resp_way   = (state_reg == RESP) ? way_reg : 2'd0;

endmodule

// File: tb/tb_phased_way_ctrl.sv
// Directed bench for phased_way_ctrl: hit, multi-match, round-robin misses,
// invalid-way miss, spurious refill_done, held request and mid-refill reset.
module tb_phased_way_ctrl;

    localparam int TAG_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [TAG_W-1:0]   req_tag;
    logic               tag_en;
    logic [4*TAG_W-1:0] tag_rd;
    logic [3:0]         way_valid;
    logic [3:0]         data_en;
    logic               data_we;
    logic               refill_req;
    logic [TAG_W-1:0]   refill_tag;
    logic               refill_done;
    logic               resp_valid;
    logic               resp_hit;
    logic [1:0]         resp_way;

    int checks = 0;
    int errors = 0;

    phased_way_ctrl #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tag     (req_tag),
        .tag_en      (tag_en),
        .tag_rd      (tag_rd),
        .way_valid   (way_valid),
        .data_en     (data_en),
        .data_we     (data_we),
        .refill_req  (refill_req),
        .refill_tag  (refill_tag),
        .refill_done (refill_done),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_way    (resp_way)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full access; n = number of REFILL cycles for a miss.
    task automatic do_access(input logic [7:0] t, input bit exp_hit, input logic [1:0] exp_way,
                             input int n, input bit hold, input bit pulse);
        logic [3:0] exp_en;
        exp_en = 4'b0001 << exp_way;
        check("idle_ready", req_ready, 1);
        req_tag   = t;
        req_valid = 1'b1;
        if (pulse) refill_done = 1'b1;
        step();
        if (!hold) req_valid = 1'b0;
        check("tag_en", tag_en, 1);
        check("tag_busy", req_ready, 0);
        check("tag_no_data", data_en, 0);
        check("tag_no_refill", refill_req, 0);
        step();
        refill_done = 1'b0;
        check("cmp_tag_en", tag_en, 0);
        check("cmp_no_data", data_en, 0);
        step();
        if (!exp_hit) begin
            for (int i = 0; i < n; i++) begin
                check("refill_req", refill_req, 1);
                check("refill_tag", refill_tag, t);
                check("refill_no_data", data_en, 0);
                if (i == n - 1) refill_done = 1'b1;
                step();
            end
            refill_done = 1'b0;
        end
        check("data_en", data_en, exp_en);
        check("data_we", data_we, !exp_hit);
        check("data_no_refill", refill_req, 0);
        check("data_no_resp", resp_valid, 0);
        step();
        if (hold) req_valid = 1'b0;
        check("resp_valid", resp_valid, 1);
        check("resp_hit", resp_hit, exp_hit);
        check("resp_way", resp_way, exp_way);
        check("resp_no_data", data_en, 0);
        step();
        check("back_ready", req_ready, 1);
        check("back_no_resp", resp_valid, 0);
        if (hold) begin
            step();
            check("hold_single_accept", tag_en, 0);
            check("hold_still_idle", req_ready, 1);
        end
        $display("access tag=0x%02h hit=%0d way=%0d refill_cycles=%0d hold=%0d pulse=%0d",
                 t, exp_hit, exp_way, exp_hit ? 0 : n, hold, pulse);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_tag     = '0;
        refill_done = 1'b0;
        way_valid   = 4'b1111;
        tag_rd      = {8'h00, 8'h5A, 8'h33, 8'h44};
        #3;
        check("rst_ready", req_ready, 1);
        check("rst_tag_en", tag_en, 0);
        check("rst_data_en", data_en, 0);
        check("rst_data_we", data_we, 0);
        check("rst_refill_req", refill_req, 0);
        check("rst_refill_tag", refill_tag, 0);
        check("rst_resp", {resp_valid, resp_hit, resp_way}, 0);
        req_valid = 1'b1;
        req_tag   = 8'h5A;
        step();
        check("rst_no_accept", tag_en, 0);
        req_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Hit in way 2.
        do_access(8'h5A, 1, 2'd2, 0, 0, 0);

        // Ways 1 and 3 alias: lowest index wins; request held through TAG/CMP.
        tag_rd = {8'h11, 8'h22, 8'h11, 8'h44};
        do_access(8'h11, 1, 2'd1, 0, 1, 0);

        // Five misses: victims 0,1,2,3 then wrap to 0.
        tag_rd = {8'h04, 8'h03, 8'h02, 8'h01};
        do_access(8'h77, 0, 2'd0, 3, 0, 0);
        do_access(8'h78, 0, 2'd1, 3, 0, 0);
        do_access(8'h79, 0, 2'd2, 3, 0, 0);
        do_access(8'h7A, 0, 2'd3, 3, 0, 0);
        do_access(8'h7B, 0, 2'd0, 1, 0, 0);

        // A hit does not advance the victim counter (still 1).
        do_access(8'h02, 1, 2'd1, 0, 0, 0);

        // Tag matches way 0 but it is invalid: miss, victim 1.
        tag_rd    = {8'h04, 8'h03, 8'h02, 8'h99};
        way_valid = 4'b1110;
        do_access(8'h99, 0, 2'd1, 4, 0, 0);

        // refill_done high in IDLE and TAG is ignored: REFILL still lasts 2 cycles, victim 2.
        way_valid = 4'b1111;
        tag_rd    = {8'h04, 8'h03, 8'h02, 8'h01};
        do_access(8'hC3, 0, 2'd2, 2, 0, 1);

        // Reset during REFILL (victim 3 pending) aborts without a response.
        check("abort_ready", req_ready, 1);
        req_tag   = 8'h55;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("abort_refill_req", refill_req, 1);
        rst_n = 1'b0;
        #1;
        check("abort_refill_drop", refill_req, 0);
        check("abort_ready_rst", req_ready, 1);
        check("abort_no_resp", resp_valid, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_quiet", {resp_valid, refill_req, data_en}, 0);
        end
        $display("access tag=0x55 aborted by reset during refill");

        // Victim counter was cleared: next miss uses way 0.
        do_access(8'h66, 0, 2'd0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
